pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller: per-stage stall and flush, jump redirect and trap drain/flush.
// Optional mem-stall watchdog is enabled by defining PIPE_CTRL_WDOG_EN.
module pipe_ctrl #(
    parameter int unsigned WDOG_LIMIT = 255,
    parameter int unsigned WDOG_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallreq_if_i,
    input  logic        stallreq_id_i,
    input  logic        stallreq_ex_i,
    input  logic        stallreq_mem_i,
    input  logic        jump_req_i,
    input  logic [31:0] jump_addr_i,
    input  logic        trap_req_i,
    input  logic [31:0] trap_addr_i,
    output logic [5:0]  stall_o,
    output logic [5:0]  flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_addr_o,
    output logic        trap_ack_o,
    output logic        wdog_timeout_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] trap_vec;
    logic        trap_capture;
    logic [5:0]  stall_prio;

    // State and trap-vector registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            trap_vec <= 32'd0;
        end else begin
            state <= state_next;
            if (trap_capture) begin
                trap_vec <= trap_addr_i;
            end
        end
    end

    // Next-state and output decode; everything reads zero while reset is held
    always_comb begin
        state_next      = state;
        trap_capture    = 1'b0;
        stall_o         = 6'b000000;
        flush_o         = 6'b000000;
        redirect_o      = 1'b0;
        redirect_addr_o = 32'd0;
        trap_ack_o      = 1'b0;

        if (stallreq_mem_i)     stall_prio = 6'b011111;
        else if (stallreq_ex_i) stall_prio = 6'b001111;
        else if (stallreq_id_i) stall_prio = 6'b000111;
        else if (stallreq_if_i) stall_prio = 6'b000011;
        else                    stall_prio = 6'b000000;

        if (!rst_n) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (trap_req_i) begin
                        // Trap wins over a concurrent jump; the trap flush clears ex
                        trap_capture = 1'b1;
                        state_next   = DRAIN;
                        stall_o      = stall_prio;
                    end else if (jump_req_i && !stallreq_ex_i && !stallreq_mem_i) begin
                        flush_o         = 6'b000110;
                        redirect_o      = 1'b1;
                        redirect_addr_o = jump_addr_i;
                    end else begin
                        stall_o = stall_prio;
                    end
                end
                DRAIN: begin
                    // Hold pc..ex so a bubble flows into ex/mem until the data bus frees
                    stall_o = stallreq_mem_i ? 6'b011111 : 6'b001111;
                    if (!stallreq_mem_i) begin
                        state_next = FLUSH;
                    end
                end
                FLUSH: begin
                    flush_o         = 6'b001110;
                    redirect_o      = 1'b1;
                    redirect_addr_o = trap_vec;
                    trap_ack_o      = 1'b1;
                    state_next      = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

`ifdef PIPE_CTRL_WDOG_EN
    logic [WDOG_W-1:0] wdog_cnt;

    // Consecutive mem-stall counter, saturating at the limit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_cnt <= '0;
        end else if (!stall_o[4]) begin
            wdog_cnt <= '0;
        end else if (wdog_cnt != WDOG_W'(WDOG_LIMIT)) begin
            wdog_cnt <= wdog_cnt + WDOG_W'(1);
        end
    end

    assign wdog_timeout_o = stall_o[4] && (wdog_cnt == WDOG_W'(WDOG_LIMIT));
`else
    assign wdog_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl; watchdog expectations follow PIPE_CTRL_WDOG_EN.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        jump_req;
    logic [31:0] jump_addr;
    logic        trap_req;
    logic [31:0] trap_addr;
    logic [5:0]  stall;
    logic [5:0]  flush;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        trap_ack;
    logic        wdog_timeout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_ctrl #(.WDOG_LIMIT(4), .WDOG_W(8)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stallreq_if_i   (stallreq_if),
        .stallreq_id_i   (stallreq_id),
        .stallreq_ex_i   (stallreq_ex),
        .stallreq_mem_i  (stallreq_mem),
        .jump_req_i      (jump_req),
        .jump_addr_i     (jump_addr),
        .trap_req_i      (trap_req),
        .trap_addr_i     (trap_addr),
        .stall_o         (stall),
        .flush_o         (flush),
        .redirect_o      (redirect),
        .redirect_addr_o (redirect_addr),
        .trap_ack_o      (trap_ack),
        .wdog_timeout_o  (wdog_timeout)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // sreq = {mem, ex, id, if}; inputs driven at negedge, outputs checked 1 time unit later
    task automatic vec(input string tag, input logic rn, input logic [3:0] sreq,
                       input logic jr, input logic [31:0] ja,
                       input logic tr, input logic [31:0] ta,
                       input logic [5:0] es, input logic [5:0] ef, input logic er,
                       input logic [31:0] ea, input logic eack, input logic ew);
        @(negedge clk);
        rst_n        = rn;
        stallreq_mem = sreq[3];
        stallreq_ex  = sreq[2];
        stallreq_id  = sreq[1];
        stallreq_if  = sreq[0];
        jump_req     = jr;
        jump_addr    = ja;
        trap_req     = tr;
        trap_addr    = ta;
        #1;
        check({tag, ".stall"},    32'(stall),         32'(es));
        check({tag, ".flush"},    32'(flush),         32'(ef));
        check({tag, ".redirect"}, 32'(redirect),      32'(er));
        check({tag, ".addr"},     redirect_addr,      ea);
        check({tag, ".ack"},      32'(trap_ack),      32'(eack));
        check({tag, ".wdog"},     32'(wdog_timeout),  32'(ew));
        if (trap_ack && stallreq_mem) begin
            check({tag, ".mem_in_flush"}, 32'(stallreq_mem), 32'd0);
        end
    endtask

    logic wd;
    localparam logic [31:0] Z = 32'd0;

    initial begin
        rst_n = 1'b0;
        {stallreq_if, stallreq_id, stallreq_ex, stallreq_mem} = 4'b0;
        jump_req = 1'b0; jump_addr = Z; trap_req = 1'b0; trap_addr = Z;

        // Reset: everything reads zero whatever the inputs
        vec("rst0", 0, 4'b1111, 1, 32'h100, 1, 32'h44, 6'h00, 6'h00, 0, Z, 0, 0);
        vec("rst1", 0, 4'b1000, 1, 32'h100, 0, Z,      6'h00, 6'h00, 0, Z, 0, 0);

        // Stall priority encoding
        vec("idle",   1, 4'b0000, 0, Z, 0, Z, 6'b000000, 6'h00, 0, Z, 0, 0);
        vec("if",     1, 4'b0001, 0, Z, 0, Z, 6'b000011, 6'h00, 0, Z, 0, 0);
        vec("id_if",  1, 4'b0011, 0, Z, 0, Z, 6'b000111, 6'h00, 0, Z, 0, 0);
        vec("mem_id", 1, 4'b1011, 0, Z, 0, Z, 6'b011111, 6'h00, 0, Z, 0, 0);
        vec("ex",     1, 4'b0110, 0, Z, 0, Z, 6'b001111, 6'h00, 0, Z, 0, 0);

        // Jump accepted same cycle; if/id requests suppressed
        vec("jmp",    1, 4'b0000, 1, 32'h100, 0, Z, 6'h00, 6'b000110, 1, 32'h100, 0, 0);
        vec("jmp_id", 1, 4'b0011, 1, 32'h1234, 0, Z, 6'h00, 6'b000110, 1, 32'h1234, 0, 0);

        // Jump blocked by ex busy for 3 cycles, taken in the 4th
        vec("jx1", 1, 4'b0100, 1, 32'h100, 0, Z, 6'b001111, 6'h00, 0, Z, 0, 0);
        vec("jx2", 1, 4'b0100, 1, 32'h100, 0, Z, 6'b001111, 6'h00, 0, Z, 0, 0);
        vec("jx3", 1, 4'b0100, 1, 32'h100, 0, Z, 6'b001111, 6'h00, 0, Z, 0, 0);
        vec("jx4", 1, 4'b0000, 1, 32'h100, 0, Z, 6'h00, 6'b000110, 1, 32'h100, 0, 0);
        vec("jm",  1, 4'b1000, 1, 32'h100, 0, Z, 6'b011111, 6'h00, 0, Z, 0, 0);

        // Trap with two mem-stalled drain cycles; jump during drain ignored
        vec("t_cap", 1, 4'b0000, 0, Z, 1, 32'h8000_0000, 6'h00, 6'h00, 0, Z, 0, 0);
        vec("t_d1",  1, 4'b1000, 1, 32'h300, 1, 32'h8000_0000, 6'b011111, 6'h00, 0, Z, 0, 0);
        vec("t_d2",  1, 4'b1000, 0, Z, 1, 32'h8000_0000, 6'b011111, 6'h00, 0, Z, 0, 0);
        vec("t_d3",  1, 4'b0000, 1, 32'h300, 1, 32'h8000_0000, 6'b001111, 6'h00, 0, Z, 0, 0);
        vec("t_fl",  1, 4'b0111, 0, Z, 1, 32'h9999_0000, 6'h00, 6'b001110, 1, 32'h8000_0000, 1, 0);
        vec("t_end", 1, 4'b0000, 0, Z, 0, Z, 6'h00, 6'h00, 0, Z, 0, 0);

        // Trap and jump in the same idle cycle: trap wins
        vec("tj_cap", 1, 4'b0000, 1, 32'h200, 1, 32'h400, 6'h00, 6'h00, 0, Z, 0, 0);
        vec("tj_d1",  1, 4'b0000, 1, 32'h200, 1, 32'h400, 6'b001111, 6'h00, 0, Z, 0, 0);
        vec("tj_fl",  1, 4'b0000, 1, 32'h200, 1, 32'h400, 6'h00, 6'b001110, 1, 32'h400, 1, 0);
        vec("tj_end", 1, 4'b0000, 0, Z, 0, Z, 6'h00, 6'h00, 0, Z, 0, 0);

        // Reset mid-drain discards the trap
        vec("rd_cap", 1, 4'b0000, 0, Z, 1, 32'h500, 6'h00, 6'h00, 0, Z, 0, 0);
        vec("rd_d1",  1, 4'b1000, 0, Z, 1, 32'h500, 6'b011111, 6'h00, 0, Z, 0, 0);
        vec("rd_rst", 0, 4'b1000, 0, Z, 1, 32'h500, 6'h00, 6'h00, 0, Z, 0, 0);
        vec("rd_p1",  1, 4'b0000, 0, Z, 0, Z, 6'h00, 6'h00, 0, Z, 0, 0);
        vec("rd_p2",  1, 4'b0000, 0, Z, 0, Z, 6'h00, 6'h00, 0, Z, 0, 0);

        // Watchdog: mem stall held 6 cycles, limit 4
        for (int i = 1; i <= 6; i++) begin
`ifdef PIPE_CTRL_WDOG_EN
            wd = (i >= 5);
`else
            wd = 1'b0;
`endif
            vec($sformatf("wd%0d", i), 1, 4'b1000, 0, Z, 0, Z, 6'b011111, 6'h00, 0, Z, 0, wd);
        end
        vec("wd_rel", 1, 4'b0000, 0, Z, 0, Z, 6'h00, 6'h00, 0, Z, 0, 0);
        vec("wd_re1", 1, 4'b1000, 0, Z, 0, Z, 6'b011111, 6'h00, 0, Z, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
